// File: rtl/ofm_pkg.sv
// Shared definitions for the TX checksum insert path: data FIFO field layout and checksum record format.
// Latency: none. This package holds types, constants and a combinational popcount helper only.
// Backpressure: not applicable.
package ofm_pkg;

  // Data FIFO word layout: {tlast, tkeep[7:0], tdata[63:0]}
  localparam int TDATA_LSB = 0;
  localparam int TKEEP_LSB = 64;
  localparam int TLAST_BIT = 72;
  localparam int DFIFO_W   = 73;

  // Checksum record: {en, insert offset, folded sum}
  localparam int SUMREC_W  = 33;

  typedef struct packed {
    logic        en;
    logic [15:0] ins;
    logic [15:0] sum;
  } sum_rec_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ins_state_t;

  // Number of valid bytes in a beat (population count of tkeep)
  function automatic logic [3:0] keep_to_cnt(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ofm_sum_queue.sv
// Per-frame checksum record queue: a C_DEPTH x C_W synchronous FIFO with first-word fall-through output.
// Latency: a pushed record is visible on pop_dat the cycle after the push.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle, so the caller must watch full.
module ofm_sum_queue #(
  parameter int C_DEPTH = 4,
  parameter int C_W     = 33
) (
  input  logic           mm2s_clk,
  input  logic           mm2s_resetn,
  input  logic           push,
  input  logic [C_W-1:0] push_dat,
  input  logic           pop,
  output logic [C_W-1:0] pop_dat,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(C_DEPTH);

  logic [C_W-1:0] mem [C_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           wr_en;
  logic           rd_en;

  // A simultaneous pop frees a slot, so a push while full is still accepted
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Record storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge mm2s_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ofm_csum_insert.sv
// Holds each TX frame in the data FIFO until its checksum record is queued, then streams it to AXI4-Stream with the checksum patched in.
// Latency: the data FIFO head appears on m_axis_tvalid 1 cycle after the pop, once a record is present.
// Backpressure: a single output register that pops a new beat only when it is empty or being drained, giving full rate with tready=1.
module ofm_csum_insert
  import ofm_pkg::*;
#(
  parameter int C_SUM_DEPTH = 4,
  parameter bit C_INVERT    = 1'b1
) (
  input  logic               mm2s_clk,
  input  logic               mm2s_resetn,
  input  logic [DFIFO_W-1:0] data_fifo_rdata,
  input  logic               data_fifo_empty,
  output logic               data_fifo_rden,
  input  logic [15:0]        TxSum,
  input  logic               TxSum_valid,
  input  logic [15:0]        TxCsInsert,
  input  logic               TxCsEn,
  output logic [63:0]        m_axis_tdata,
  output logic [7:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               sum_q_full,
  output logic               sum_ovf,
  output logic               insert_miss
);

  ins_state_t            state_q, state_d;
  logic [SUMREC_W-1:0]   q_pop_dat;
  sum_rec_t              q_rec;
  logic                  q_full, q_empty;
  logic                  rec_pop, beat_pop;

  logic [15:0]           csum_q, ins_q, bcnt_q;
  logic                  en_q, msb_done_q, lsb_done_q;
  logic [15:0]           ins_p1;

  logic [63:0]           fifo_dat;
  logic [7:0]            fifo_keep;
  logic                  fifo_last;
  logic [63:0]           pat_dat;
  logic                  hit_msb, hit_lsb;

  logic                  out_vld;
  logic [63:0]           out_dat;
  logic [7:0]            out_keep;
  logic                  out_last;

  assign fifo_dat  = data_fifo_rdata[TDATA_LSB +: 64];
  assign fifo_keep = data_fifo_rdata[TKEEP_LSB +: 8];
  assign fifo_last = data_fifo_rdata[TLAST_BIT];
  assign q_rec     = sum_rec_t'(q_pop_dat);
  assign ins_p1    = ins_q + 16'd1;

  ofm_sum_queue #(
    .C_DEPTH (C_SUM_DEPTH),
    .C_W     (SUMREC_W)
  ) u_sum_queue (
    .mm2s_clk    (mm2s_clk),
    .mm2s_resetn (mm2s_resetn),
    .push        (TxSum_valid),
    .push_dat    ({TxCsEn, TxCsInsert, TxSum}),
    .pop         (rec_pop),
    .pop_dat     (q_pop_dat),
    .full        (q_full),
    .empty       (q_empty)
  );

  // State register
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state, record pop and beat pop; a new record is taken on the tlast beat when one is already waiting
  always_comb begin
    state_d  = state_q;
    rec_pop  = 1'b0;
    beat_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          rec_pop = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        beat_pop = !data_fifo_empty && (!out_vld || m_axis_tready);
        if (beat_pop && fifo_last) begin
          if (!q_empty) rec_pop = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_fifo_rden = beat_pop;

  // Lane patch: lane i carries frame byte bcnt+i; only kept lanes may be overwritten
  always_comb begin
    pat_dat = fifo_dat;
    hit_msb = 1'b0;
    hit_lsb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (en_q && fifo_keep[i]) begin
        if (bcnt_q + 16'(i) == ins_q) begin
          pat_dat[8*i +: 8] = csum_q[15:8];
          hit_msb           = 1'b1;
        end
        if (bcnt_q + 16'(i) == ins_p1) begin
          pat_dat[8*i +: 8] = csum_q[7:0];
          hit_lsb           = 1'b1;
        end
      end
    end
  end

  // Working record and frame byte counter; a record load restarts the count for the next frame
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      csum_q     <= '0;
      ins_q      <= '0;
      en_q       <= 1'b0;
      bcnt_q     <= '0;
      msb_done_q <= 1'b0;
      lsb_done_q <= 1'b0;
    end else if (rec_pop) begin
      csum_q     <= C_INVERT ? ~q_rec.sum : q_rec.sum;
      ins_q      <= q_rec.ins;
      en_q       <= q_rec.en;
      bcnt_q     <= '0;
      msb_done_q <= 1'b0;
      lsb_done_q <= 1'b0;
    end else if (beat_pop) begin
      bcnt_q     <= bcnt_q + {12'd0, keep_to_cnt(fifo_keep)};
      msb_done_q <= msb_done_q | hit_msb;
      lsb_done_q <= lsb_done_q | hit_lsb;
    end
  end

  // Sticky error flags: dropped record, and checksum bytes not fully placed by the end of the frame
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      sum_ovf     <= 1'b0;
      insert_miss <= 1'b0;
    end else begin
      if (TxSum_valid && q_full && !rec_pop)
        sum_ovf <= 1'b1;
      if (beat_pop && fifo_last && en_q &&
          !((msb_done_q | hit_msb) && (lsb_done_q | hit_lsb)))
        insert_miss <= 1'b1;
    end
  end

  // Output register: load on pop, hold while stalled, empty when drained with nothing behind it
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else if (beat_pop) begin
      out_vld  <= 1'b1;
      out_dat  <= pat_dat;
      out_keep <= fifo_keep;
      out_last <= fifo_last;
    end else if (m_axis_tready) begin
      out_vld  <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_dat;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tlast  = out_last;
  assign sum_q_full    = q_full;

endmodule

// File: tb/tb_ofm_csum_insert.sv
// Bench for ofm_csum_insert: a byte-level frame model predicts every output beat and sticky flag.
// Timing: inputs change on the falling edge and outputs are sampled there, away from the rising edge.
// Handshake: the data FIFO is a queue that pops on rden; output beats are collected on tvalid&&tready.
module tb_ofm_csum_insert;

  localparam bit INV   = 1'b1;
  localparam int DEPTH = 4;

  logic        mm2s_clk = 1'b0;
  logic        mm2s_resetn;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [15:0] TxSum;
  logic        TxSum_valid;
  logic [15:0] TxCsInsert;
  logic        TxCsEn;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sum_q_full;
  logic        sum_ovf;
  logic        insert_miss;

  ofm_csum_insert #(.C_SUM_DEPTH(DEPTH), .C_INVERT(INV)) dut (
    .mm2s_clk        (mm2s_clk),
    .mm2s_resetn     (mm2s_resetn),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .TxSum           (TxSum),
    .TxSum_valid     (TxSum_valid),
    .TxCsInsert      (TxCsInsert),
    .TxCsEn          (TxCsEn),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .sum_q_full      (sum_q_full),
    .sum_ovf         (sum_ovf),
    .insert_miss     (insert_miss)
  );

  always #5 mm2s_clk = ~mm2s_clk;

  // Beats are {tlast, tkeep, tdata}
  logic [72:0] dq[$];
  logic [72:0] exq[$];
  logic [72:0] rx[$];
  int          nvec = 0;
  int          nerr = 0;
  int          stall_viol = 0;
  logic        stalled = 1'b0;
  logic [72:0] held = '0;

  task automatic refresh();
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = (dq.size() != 0) ? dq[0] : '0;
  endtask

  // One clock: called at a falling edge, returns at the next falling edge
  task automatic step();
    logic        rd, tv, tr;
    logic [72:0] ob, junk;
    #1;
    rd = data_fifo_rden;
    tv = m_axis_tvalid;
    tr = m_axis_tready;
    ob = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (stalled && (!tv || ob !== held)) stall_viol++;
    stalled = tv && !tr;
    held    = ob;
    @(posedge mm2s_clk);
    #1;
    if (rd && dq.size() != 0) junk = dq.pop_front();
    if (tv && tr) rx.push_back(ob);
    refresh();
    @(negedge mm2s_clk);
  endtask

  task automatic strobe(input logic [15:0] s, input logic [15:0] ins, input logic en);
    TxSum       = s;
    TxCsInsert  = ins;
    TxCsEn      = en;
    TxSum_valid = 1'b1;
    step();
    TxSum_valid = 1'b0;
  endtask

  // Random frame into the FIFO model; the expected beats come from patching the frame's byte array
  task automatic push_frame(input int len, input logic [15:0] s, input logic [15:0] ins,
                            input logic en, output logic miss);
    logic [7:0]  fb [256];
    logic [7:0]  eb [256];
    logic [15:0] eff;
    logic [63:0] d, e;
    logic [7:0]  k;
    int          n, ix;
    eff = INV ? ~s : s;
    ix  = int'(ins);
    for (int i = 0; i < len; i++) begin
      fb[i] = 8'($urandom);
      eb[i] = fb[i];
    end
    if (en && ix < len)     eb[ix]   = eff[15:8];
    if (en && ix + 1 < len) eb[ix+1] = eff[7:0];
    miss = en && !(ix + 1 < len);
    for (int s0 = 0; s0 < len; s0 += 8) begin
      n = (len - s0 < 8) ? len - s0 : 8;
      d = '0;
      e = '0;
      k = 8'((1 << n) - 1);
      for (int l = 0; l < n; l++) begin
        d[8*l +: 8] = fb[s0+l];
        e[8*l +: 8] = eb[s0+l];
      end
      dq.push_back({(s0 + 8 >= len), k, d});
      exq.push_back({(s0 + 8 >= len), k, e});
    end
    refresh();
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while (rx.size() < exq.size() && n < budget) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    m_axis_tready = 1'b1;
    step();
    step();
  endtask

  task automatic clear_lists();
    rx.delete();
    exq.delete();
    stall_viol = 0;
  endtask

  task automatic test_reset();
    mm2s_resetn   = 1'b0;
    TxSum         = '0;
    TxSum_valid   = 1'b0;
    TxCsInsert    = '0;
    TxCsEn        = 1'b0;
    m_axis_tready = 1'b1;
    refresh();
    @(negedge mm2s_clk);
    @(negedge mm2s_clk);
    nvec++; if (m_axis_tvalid !== 1'b0)  begin nerr++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    nvec++; if (data_fifo_rden !== 1'b0) begin nerr++; $display("FAIL reset_rden got %b exp 0", data_fifo_rden); end
    nvec++; if (sum_ovf !== 1'b0)        begin nerr++; $display("FAIL reset_sum_ovf got %b exp 0", sum_ovf); end
    nvec++; if (insert_miss !== 1'b0)    begin nerr++; $display("FAIL reset_insert_miss got %b exp 0", insert_miss); end
    nvec++; if (sum_q_full !== 1'b0)     begin nerr++; $display("FAIL reset_sum_q_full got %b exp 0", sum_q_full); end
    mm2s_resetn = 1'b1;
    @(negedge mm2s_clk);
  endtask

  task automatic test_basic();
    logic        miss;
    logic [72:0] b3, b7;
    clear_lists();
    push_frame(60, 16'h1234, 16'd24, 1'b1, miss);
    strobe(16'h1234, 16'd24, 1'b1);
    drain(100, 1'b0);
    nvec++; if (rx.size() !== exq.size()) begin nerr++; $display("FAIL basic_beats got %0d exp %0d", rx.size(), exq.size()); end
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL basic_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    b3 = (rx.size() > 3) ? rx[3] : 'x;
    b7 = (rx.size() > 7) ? rx[7] : 'x;
    nvec++; if (b3[15:0] !== 16'hCBED)  begin nerr++; $display("FAIL basic_bytes24_25 got %h exp cbed", b3[15:0]); end
    nvec++; if (b7[72:64] !== 9'h10F)   begin nerr++; $display("FAIL basic_last_beat got %h exp 10f", b7[72:64]); end
    nvec++; if (insert_miss !== miss)   begin nerr++; $display("FAIL basic_insert_miss got %b exp %b", insert_miss, miss); end
  endtask

  task automatic test_straddle();
    logic        miss;
    logic [72:0] b1, b2;
    clear_lists();
    // 0x5AA5 is inserted inverted, so 0xA55A lands in the frame
    push_frame(40, 16'h5AA5, 16'd15, 1'b1, miss);
    strobe(16'h5AA5, 16'd15, 1'b1);
    drain(100, 1'b0);
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL straddle_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    b1 = (rx.size() > 1) ? rx[1] : 'x;
    b2 = (rx.size() > 2) ? rx[2] : 'x;
    nvec++; if (b1[63:56] !== 8'hA5) begin nerr++; $display("FAIL straddle_msb got %h exp a5", b1[63:56]); end
    nvec++; if (b2[7:0] !== 8'h5A)   begin nerr++; $display("FAIL straddle_lsb got %h exp 5a", b2[7:0]); end
    nvec++; if (insert_miss !== miss) begin nerr++; $display("FAIL straddle_insert_miss got %b exp %b", insert_miss, miss); end
  endtask

  task automatic test_hold_for_record();
    logic        miss;
    logic [15:0] s;
    int          bad = 0;
    int          k   = 0;
    clear_lists();
    s = 16'($urandom);
    push_frame(24, s, 16'd3, 1'b1, miss);
    for (int c = 0; c < 20; c++) begin
      if (data_fifo_rden || m_axis_tvalid) bad++;
      step();
    end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL hold_no_record got %0d active cycles exp 0", bad); end
    strobe(s, 16'd3, 1'b1);
    while (!m_axis_tvalid && k < 10) begin
      step();
      k++;
    end
    nvec++; if (k !== 2) begin nerr++; $display("FAIL hold_latency got %0d cycles exp 2", k); end
    drain(100, 1'b0);
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL hold_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        miss;
    logic [15:0] s, ins;
    int          len;
    clear_lists();
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 50);
      s   = 16'($urandom);
      ins = 16'($urandom_range(0, 60));
      push_frame(len, s, ins, 1'b0, miss);
      strobe(s, ins, 1'b0);
    end
    drain(2000, 1'b1);
    nvec++; if (rx.size() !== exq.size()) begin nerr++; $display("FAIL bp_beats got %0d exp %0d", rx.size(), exq.size()); end
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL bp_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    nvec++; if (stall_viol !== 0) begin nerr++; $display("FAIL bp_stall_stable got %0d changes exp 0", stall_viol); end
  endtask

  task automatic test_overflow();
    logic [15:0] s   [6];
    logic [15:0] ins [6];
    int          len [6];
    logic        miss;
    clear_lists();
    for (int i = 0; i < 6; i++) begin
      len[i] = $urandom_range(16, 40);
      s[i]   = 16'($urandom);
      ins[i] = 16'($urandom_range(0, len[i] - 2));
    end
    // The first record moves straight into the working registers, so four more fill the queue
    for (int i = 0; i < 5; i++) strobe(s[i], ins[i], 1'b1);
    nvec++; if (sum_q_full !== 1'b1) begin nerr++; $display("FAIL ovf_full got %b exp 1", sum_q_full); end
    nvec++; if (sum_ovf !== 1'b0)    begin nerr++; $display("FAIL ovf_early got %b exp 0", sum_ovf); end
    strobe(s[5], ins[5], 1'b1);
    nvec++; if (sum_ovf !== 1'b1)    begin nerr++; $display("FAIL ovf_sticky got %b exp 1", sum_ovf); end
    for (int i = 0; i < 5; i++) push_frame(len[i], s[i], ins[i], 1'b1, miss);
    drain(500, 1'b0);
    nvec++; if (rx.size() !== exq.size()) begin nerr++; $display("FAIL ovf_beats got %0d exp %0d", rx.size(), exq.size()); end
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL ovf_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    nvec++; if (sum_q_full !== 1'b0) begin nerr++; $display("FAIL ovf_drained_full got %b exp 0", sum_q_full); end
  endtask

  task automatic test_miss_then_reset();
    logic        miss;
    logic [72:0] b7;
    int          k = 0;
    clear_lists();
    push_frame(63, 16'h3C5A, 16'd62, 1'b1, miss);
    strobe(16'h3C5A, 16'd62, 1'b1);
    drain(100, 1'b0);
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL miss_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    b7 = (rx.size() > 7) ? rx[7] : 'x;
    nvec++; if (b7[55:48] !== 8'hC3)  begin nerr++; $display("FAIL miss_byte62 got %h exp c3", b7[55:48]); end
    nvec++; if (insert_miss !== miss) begin nerr++; $display("FAIL miss_flag got %b exp %b", insert_miss, miss); end

    // Stall a frame mid-flight, then reset
    clear_lists();
    m_axis_tready = 1'b0;
    push_frame(40, 16'h1111, 16'd5, 1'b1, miss);
    strobe(16'h1111, 16'd5, 1'b1);
    while (!m_axis_tvalid && k < 10) begin
      step();
      k++;
    end
    step();
    mm2s_resetn = 1'b0;
    #1;
    nvec++; if (m_axis_tvalid !== 1'b0) begin nerr++; $display("FAIL rst_mid_tvalid got %b exp 0", m_axis_tvalid); end
    nvec++; if (insert_miss !== 1'b0)   begin nerr++; $display("FAIL rst_mid_insert_miss got %b exp 0", insert_miss); end
    nvec++; if (sum_ovf !== 1'b0)       begin nerr++; $display("FAIL rst_mid_sum_ovf got %b exp 0", sum_ovf); end
    dq.delete();
    clear_lists();
    refresh();
    stalled       = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge mm2s_clk);
    mm2s_resetn = 1'b1;
    @(negedge mm2s_clk);

    push_frame(20, 16'hBEEF, 16'd9, 1'b1, miss);
    strobe(16'hBEEF, 16'd9, 1'b1);
    drain(100, 1'b0);
    nvec++; if (rx.size() !== exq.size()) begin nerr++; $display("FAIL post_rst_beats got %0d exp %0d", rx.size(), exq.size()); end
    for (int b = 0; b < exq.size(); b++) begin
      nvec++;
      if (b >= rx.size() || rx[b] !== exq[b]) begin
        nerr++; $display("FAIL post_rst_beat%0d got %h exp %h", b, (b < rx.size()) ? rx[b] : 73'bx, exq[b]);
      end
    end
    nvec++; if (insert_miss !== miss) begin nerr++; $display("FAIL post_rst_insert_miss got %b exp %b", insert_miss, miss); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_straddle();
    test_hold_for_record();
    test_backpressure();
    test_overflow();
    test_miss_then_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
